// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: queued words go out back-to-back with
// configurable data width, parity and stop bits.
module uart_tx_fifo #(
    parameter int  CLK_FREQ   = 100_000_000,
    parameter int  BAUD       = 115200,
    parameter int  DATA_BITS  = 8,
    parameter int  PARITY     = 0,
    parameter int  STOP_BITS  = 1,
    parameter int  FIFO_DEPTH = 16,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    input  logic                 tx_flush,
    output logic [LW-1:0]        fifo_level,
    output logic                 overflow,
    output logic                 uart_tx_busy,
    output logic                 uart_txd
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int AW       = LW - 1;
    localparam int CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [LW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 ovf_q, ovf_d;
    logic                 full, empty, push, pop;
    logic [DATA_BITS-1:0] head;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [2:0]           bit_q;
    logic                 txd_q, busy_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 bit_end, last_data, last_stop, shift_en;

    // Extra MSB on the pointers separates full (MSBs differ) from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign bit_end   = (cnt_q == CNT_LAST);
    assign last_data = (bit_q == 3'(DATA_BITS - 1));
    assign last_stop = (bit_q == 3'(STOP_BITS - 1));
    assign shift_en  = (state_q == S_DATA) && bit_end;

    assign push = tx_valid && !full && !tx_flush;
    assign pop  = !empty && !tx_flush &&
                  ((state_q == S_IDLE) ||
                   ((state_q == S_STOP) && bit_end && last_stop));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (tx_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (tx_valid && full)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
    end

    // Payload and its parity are captured at pop so the FIFO slot is free at once.
    always_ff @(posedge sys_clk) begin
        if (pop) begin
            shift_q <= head;
            par_q   <= parity_of(head);
        end else if (shift_en) begin
            shift_q <= shift_q >> 1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            if (state_q == S_IDLE || bit_end)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;

            case (state_q)
                S_IDLE: begin
                    bit_q <= '0;
                    if (pop) begin
                        state_q <= S_START;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state_q <= S_DATA;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (last_data) begin
                            bit_q <= '0;
                            if (PARITY != 0) begin
                                state_q <= S_PARITY;
                                txd_q   <= par_q;
                            end else begin
                                state_q <= S_STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            txd_q <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state_q <= S_STOP;
                        bit_q   <= '0;
                        txd_q   <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            bit_q <= '0;
                            if (pop) begin
                                state_q <= S_START;
                                txd_q   <= 1'b0;
                            end else begin
                                state_q <= S_IDLE;
                                txd_q   <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready     = !full;
    assign fifo_level   = wr_ptr_q - rd_ptr_q;
    assign overflow     = ovf_q;
    assign uart_tx_busy = busy_q;
    assign uart_txd     = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three instances (8N1, 8O1, 5E2) at BAUD_DIV=10,
// a line decoder per instance pops expected words and compares them.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid [3];
    logic       flush [3];
    logic [7:0] data  [3];
    logic       ready [3];
    logic [4:0] lvl   [3];
    logic       ovf   [3];
    logic       busy  [3];
    logic       txd   [3];

    int n_tests = 0;
    int n_fail  = 0;
    int q0[$], q1[$], q2[$];
    int cyc = 0;
    int rise_t[3], fall_t[3];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000)) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(valid[0]), .tx_data(data[0]),
        .tx_ready(ready[0]), .tx_flush(flush[0]), .fifo_level(lvl[0]), .overflow(ovf[0]),
        .uart_tx_busy(busy[0]), .uart_txd(txd[0]));

    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .PARITY(1)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(valid[1]), .tx_data(data[1]),
        .tx_ready(ready[1]), .tx_flush(flush[1]), .fifo_level(lvl[1]), .overflow(ovf[1]),
        .uart_tx_busy(busy[1]), .uart_txd(txd[1]));

    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_BITS(5),
                   .PARITY(2), .STOP_BITS(2)) u_c (
        .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(valid[2]), .tx_data(data[2][4:0]),
        .tx_ready(ready[2]), .tx_flush(flush[2]), .fifo_level(lvl[2]), .overflow(ovf[2]),
        .uart_tx_busy(busy[2]), .uart_txd(txd[2]));

    function automatic int nb(input int k);
        return (k == 2) ? 5 : 8;
    endfunction
    function automatic int hp(input int k);
        return (k == 0) ? 0 : 1;
    endfunction
    function automatic int ns(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input int k, input int d, input int p);
        int v;
        v = d | (p << 8);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic int q_size(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic int q_pop(input int k);
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic frame_done(input int k, input int d, input int p, input int bad);
        int e;
        if (q_size(k) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_unexpected dut%0d: got data 0x%0h, required no frame", k, d);
        end else begin
            e = q_pop(k);
            chk($sformatf("frame_data_dut%0d", k), d, e & 'hff);
            if (hp(k) != 0)
                chk($sformatf("frame_parity_dut%0d", k), p, (e >> 8) & 1);
            chk($sformatf("frame_start_stop_dut%0d", k), bad, 0);
        end
    endtask

    // Line decoder: samples each bit mid-way, 5 cycles after the bit starts.
    int act[3], off[3], rdat[3], rpar[3], rbad[3];
    initial begin
        int idx;
        for (int k = 0; k < 3; k++) act[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    act[k] = 0;
                end else if (act[k] == 0) begin
                    if (txd[k] == 1'b0) begin
                        act[k] = 1; off[k] = 0; rdat[k] = 0; rpar[k] = 0; rbad[k] = 0;
                    end
                end else begin
                    off[k]++;
                    if (off[k] % 10 == 5) begin
                        idx = off[k] / 10;
                        if (idx == 0) begin
                            if (txd[k] != 1'b0) rbad[k] = 1;
                        end else if (idx <= nb(k)) begin
                            rdat[k] = rdat[k] | (int'(txd[k]) << (idx - 1));
                        end else if (hp(k) != 0 && idx == nb(k) + 1) begin
                            rpar[k] = int'(txd[k]);
                        end else if (txd[k] != 1'b1) begin
                            rbad[k] = 1;
                        end
                        if (idx == nb(k) + hp(k) + ns(k)) begin
                            act[k] = 0;
                            frame_done(k, rdat[k], rpar[k], rbad[k]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic prevb [3];
        for (int k = 0; k < 3; k++) begin prevb[k] = 1'b0; rise_t[k] = 0; fall_t[k] = 0; end
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 3; k++) begin
                if (busy[k] && !prevb[k]) rise_t[k] = cyc;
                if (!busy[k] && prevb[k]) fall_t[k] = cyc;
                prevb[k] = busy[k];
            end
        end
    end

    task automatic wait_idle(input int k, input int budget);
        int n;
        n = 0;
        while ((busy[k] || lvl[k] != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_timeout_dut%0d", k), (n < budget) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin valid[k] = 1'b0; flush[k] = 1'b0; data[k] = '0; end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready_dut%0d", k), ready[k], 1);
            chk($sformatf("rst_level_dut%0d", k), lvl[k], 0);
            chk($sformatf("rst_overflow_dut%0d", k), ovf[k], 0);
            chk($sformatf("rst_busy_dut%0d", k), busy[k], 0);
            chk($sformatf("rst_txd_dut%0d", k), txd[k], 1);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 single word: start bit appears on the second edge after the push edge
        expect_word(0, 'h55, 0);
        valid[0] = 1'b1; data[0] = 8'h55;
        @(negedge clk);
        valid[0] = 1'b0;
        chk("t1_txd_after_push", txd[0], 1);
        chk("t1_level_after_push", lvl[0], 1);
        @(negedge clk);
        chk("t1_txd_start", txd[0], 0);
        chk("t1_busy_start", busy[0], 1);
        chk("t1_level_after_pop", lvl[0], 0);
        wait_idle(0, 300);
        chk("t1_busy_len", fall_t[0] - rise_t[0], 100);

        // Parity: odd on dut1 (8 bits), even on dut2 (5 bits, 2 stops)
        expect_word(1, 'h03, 1);
        expect_word(2, 'h15, 1);
        valid[1] = 1'b1; data[1] = 8'h03;
        valid[2] = 1'b1; data[2] = 8'h15;
        @(negedge clk);
        valid[1] = 1'b0; valid[2] = 1'b0;
        wait_idle(1, 300);
        wait_idle(2, 300);
        chk("t2_busy_len_odd", fall_t[1] - rise_t[1], 110);
        chk("t2_busy_len_5e2", fall_t[2] - rise_t[2], 90);

        expect_word(1, 'h80, 0);
        expect_word(1, 'h7e, 1);
        expect_word(2, 'h03, 0);
        expect_word(2, 'h1f, 1);
        valid[1] = 1'b1; data[1] = 8'h80;
        valid[2] = 1'b1; data[2] = 8'h03;
        @(negedge clk);
        data[1] = 8'h7e; data[2] = 8'h1f;
        @(negedge clk);
        valid[1] = 1'b0; valid[2] = 1'b0;
        wait_idle(1, 500);
        wait_idle(2, 500);
        chk("t2_pair_len_odd", fall_t[1] - rise_t[1], 220);
        chk("t2_pair_len_5e2", fall_t[2] - rise_t[2], 180);

        // Burst of 18: word 0 leaves the FIFO one edge after entering, so 17 fit and the 18th overflows
        for (int i = 0; i < 17; i++) expect_word(0, i, 0);
        for (int i = 0; i < 18; i++) begin
            if (i == 17) begin
                chk("t3_level_full", lvl[0], 16);
                chk("t3_ready_full", ready[0], 0);
                chk("t3_overflow_before", ovf[0], 0);
            end
            valid[0] = 1'b1; data[0] = 8'(i);
            @(negedge clk);
        end
        valid[0] = 1'b0;
        chk("t3_overflow_set", ovf[0], 1);
        chk("t3_level_after_refuse", lvl[0], 16);
        wait_idle(0, 2500);
        chk("t3_busy_len", fall_t[0] - rise_t[0], 1700);
        chk("t3_overflow_sticky", ovf[0], 1);

        // Flush mid-frame: the word on the line completes, queued words vanish
        expect_word(0, 'ha0, 0);
        for (int i = 0; i < 6; i++) begin
            valid[0] = 1'b1; data[0] = 8'(8'ha0 + i);
            @(negedge clk);
        end
        valid[0] = 1'b0;
        repeat (25) @(negedge clk);
        chk("t4_level_before_flush", lvl[0], 5);
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0;
        chk("t4_level_flushed", lvl[0], 0);
        chk("t4_overflow_cleared", ovf[0], 0);
        chk("t4_busy_in_flight", busy[0], 1);
        wait_idle(0, 300);
        chk("t4_busy_len", fall_t[0] - rise_t[0], 100);
        repeat (150) @(negedge clk);
        chk("t4_busy_after", busy[0], 0);

        // Reset during data bit 3 of 0x37 (bit 3 = 0): line returns high at once
        for (int i = 0; i < 3; i++) begin
            valid[0] = 1'b1; data[0] = (i == 0) ? 8'h37 : 8'(8'h11 * i);
            @(negedge clk);
        end
        valid[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk("t5_txd_bit3", txd[0], 0);
        rst_n = 1'b0;
        #1;
        chk("t5_txd_reset", txd[0], 1);
        chk("t5_busy_reset", busy[0], 0);
        chk("t5_level_reset", lvl[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd[0] == 1'b0) lows++;
        end
        chk("t5_line_idle", lows, 0);
        chk("t5_level_after", lvl[0], 0);
        chk("t5_busy_after", busy[0], 0);

        for (int k = 0; k < 3; k++)
            chk($sformatf("scoreboard_drained_dut%0d", k), q_size(k), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
